// File: rtl/pkt_core_dispatcher_pkg.sv
// Shared definitions for the packet core dispatcher: FSM state encoding,
// the default core count and the end-of-packet detection rule.
package pkt_core_dispatcher_pkg;

    // Both the ingress and egress machines use the same two-state encoding.
    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } fsm_state_t;

    localparam int NUM_CORES_DEFAULT = 4;

    // A packet ends on an accepted word with non-zero ctrl whose predecessor
    // in the same packet carried ctrl == 0. Leading module headers also carry
    // non-zero ctrl but are never preceded by a payload word, so they do not match.
    function automatic logic is_eop(input logic accepted,
                                    input logic ctrl_nonzero,
                                    input logic prev_ctrl_zero);
        return accepted & ctrl_nonzero & prev_ctrl_zero;
    endfunction

endpackage

// File: rtl/pkt_core_dispatcher_rr_arbiter.sv
// Round-robin search: returns the first set request at or after last + 1,
// wrapping around, with last itself being the lowest priority.
module rr_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int SEL_BITS = 2
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [SEL_BITS-1:0] last,
    output logic [SEL_BITS-1:0] grant,
    output logic                valid
);

    // Scan from the farthest candidate to the nearest so the nearest hit wins.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            logic [SEL_BITS-1:0] idx;
            idx = last + SEL_BITS'(k);
            if (req[idx]) begin
                grant = idx;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pkt_core_dispatcher.sv
// Packet dispatcher/merger between the router datapath and NUM_CORES cores.
// Ingress steers whole packets round-robin to idle cores with a combinational
// data path; egress grants one requesting core at a time and forwards its
// packet through a single registered output stage.
//
// Handshake: a word moves when its write strobe and the matching ready are
// both high in the same cycle. Ready never depends on the strobe; a sender may
// hold its strobe high while ready is low without the word being taken.
module pkt_core_dispatcher
    import pkt_core_dispatcher_pkg::*;
#(
    parameter int DATA_WIDTH    = 64,
    parameter int CTRL_WIDTH    = DATA_WIDTH / 8,
    parameter int NUM_CORES     = NUM_CORES_DEFAULT,
    parameter int CORE_SEL_BITS = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [DATA_WIDTH-1:0]            in_data,
    input  logic [CTRL_WIDTH-1:0]            in_ctrl,
    input  logic                             in_wr,
    output logic                             in_rdy,
    output logic [DATA_WIDTH-1:0]            core_in_data,
    output logic [CTRL_WIDTH-1:0]            core_in_ctrl,
    output logic [NUM_CORES-1:0]             core_in_wr,
    input  logic [NUM_CORES-1:0]             core_in_rdy,
    input  logic [NUM_CORES-1:0]             core_out_req,
    input  logic [NUM_CORES*DATA_WIDTH-1:0]  core_out_data,
    input  logic [NUM_CORES*CTRL_WIDTH-1:0]  core_out_ctrl,
    input  logic [NUM_CORES-1:0]             core_out_wr,
    output logic [NUM_CORES-1:0]             core_out_rdy,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [CTRL_WIDTH-1:0]            out_ctrl,
    output logic                             out_wr,
    input  logic                             out_rdy,
    output logic [CORE_SEL_BITS-1:0]         in_core_sel,
    output logic [CORE_SEL_BITS-1:0]         out_core_sel,
    output logic [31:0]                      pkt_in_cnt,
    output logic [31:0]                      pkt_out_cnt
);

    localparam logic [CORE_SEL_BITS-1:0] LAST_CORE = CORE_SEL_BITS'(NUM_CORES - 1);

    fsm_state_t               in_state;
    logic [CORE_SEL_BITS-1:0] last_in;
    logic                     in_prev_zero;
    logic [CORE_SEL_BITS-1:0] in_grant;
    logic                     in_grant_valid;
    logic                     in_accept;
    logic                     in_eop;

    fsm_state_t               out_state;
    logic [CORE_SEL_BITS-1:0] last_out;
    logic                     out_prev_zero;
    logic [CORE_SEL_BITS-1:0] out_grant;
    logic                     out_grant_valid;
    logic [DATA_WIDTH-1:0]    sel_data;
    logic [CTRL_WIDTH-1:0]    sel_ctrl;
    logic                     out_accept;
    logic                     out_eop;

    // ---------------- ingress ----------------

    rr_arbiter #(.NUM_REQ(NUM_CORES), .SEL_BITS(CORE_SEL_BITS)) u_in_arb (
        .req   (core_in_rdy),
        .last  (last_in),
        .grant (in_grant),
        .valid (in_grant_valid)
    );

    assign core_in_data = in_data;
    assign core_in_ctrl = in_ctrl;
    assign in_rdy       = (in_state == XFER) && core_in_rdy[in_core_sel];
    assign in_accept    = in_wr && in_rdy;
    assign core_in_wr   = in_accept ? (NUM_CORES'(1) << in_core_sel) : '0;
    assign in_eop       = is_eop(in_accept, |in_ctrl, in_prev_zero);

    // Ingress FSM: pick an idle core, stream one packet to it, then re-arbitrate.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_state     <= IDLE;
            in_core_sel  <= '0;
            last_in      <= LAST_CORE;
            in_prev_zero <= 1'b0;
            pkt_in_cnt   <= '0;
        end else begin
            case (in_state)
                IDLE: begin
                    if (in_grant_valid) begin
                        in_core_sel  <= in_grant;
                        in_prev_zero <= 1'b0;
                        in_state     <= XFER;
                    end
                end
                XFER: begin
                    if (in_eop) begin
                        last_in    <= in_core_sel;
                        pkt_in_cnt <= pkt_in_cnt + 32'd1;
                        in_state   <= IDLE;
                    end else if (in_accept) begin
                        in_prev_zero <= ~|in_ctrl;
                    end
                end
                default: in_state <= IDLE;
            endcase
        end
    end

    // ---------------- egress ----------------

    rr_arbiter #(.NUM_REQ(NUM_CORES), .SEL_BITS(CORE_SEL_BITS)) u_out_arb (
        .req   (core_out_req),
        .last  (last_out),
        .grant (out_grant),
        .valid (out_grant_valid)
    );

    assign sel_data     = core_out_data[out_core_sel*DATA_WIDTH +: DATA_WIDTH];
    assign sel_ctrl     = core_out_ctrl[out_core_sel*CTRL_WIDTH +: CTRL_WIDTH];
    assign core_out_rdy = ((out_state == XFER) && out_rdy) ? (NUM_CORES'(1) << out_core_sel) : '0;
    assign out_accept   = core_out_wr[out_core_sel] && core_out_rdy[out_core_sel];
    assign out_eop      = is_eop(out_accept, |sel_ctrl, out_prev_zero);

    // Egress FSM plus output register: requests are only looked at while idle,
    // so a core dropping its request mid-packet still finishes the packet.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_state     <= IDLE;
            out_core_sel  <= '0;
            last_out      <= LAST_CORE;
            out_prev_zero <= 1'b0;
            pkt_out_cnt   <= '0;
            out_wr        <= 1'b0;
            out_data      <= '0;
            out_ctrl      <= '0;
        end else begin
            out_wr <= out_accept;
            if (out_accept) begin
                out_data <= sel_data;
                out_ctrl <= sel_ctrl;
            end
            case (out_state)
                IDLE: begin
                    if (out_grant_valid) begin
                        out_core_sel  <= out_grant;
                        out_prev_zero <= 1'b0;
                        out_state     <= XFER;
                    end
                end
                XFER: begin
                    if (out_eop) begin
                        last_out    <= out_core_sel;
                        pkt_out_cnt <= pkt_out_cnt + 32'd1;
                        out_state   <= IDLE;
                    end else if (out_accept) begin
                        out_prev_zero <= ~|sel_ctrl;
                    end
                end
                default: out_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pkt_core_dispatcher.sv
// Directed testbench for pkt_core_dispatcher: ingress round-robin dispatch,
// stall handling, egress merge ordering and latency, out_rdy throttling and
// asynchronous reset in the middle of traffic.
module tb_pkt_core_dispatcher;

    localparam int DW = 64;
    localparam int CW = 8;
    localparam int NC = 4;
    localparam int SB = 2;

    logic               clk;
    logic               reset;
    logic [DW-1:0]      in_data;
    logic [CW-1:0]      in_ctrl;
    logic               in_wr;
    logic               in_rdy;
    logic [DW-1:0]      core_in_data;
    logic [CW-1:0]      core_in_ctrl;
    logic [NC-1:0]      core_in_wr;
    logic [NC-1:0]      core_in_rdy;
    logic [NC-1:0]      core_out_req;
    logic [NC*DW-1:0]   core_out_data;
    logic [NC*CW-1:0]   core_out_ctrl;
    logic [NC-1:0]      core_out_wr;
    logic [NC-1:0]      core_out_rdy;
    logic [DW-1:0]      out_data;
    logic [CW-1:0]      out_ctrl;
    logic               out_wr;
    logic               out_rdy;
    logic [SB-1:0]      in_core_sel;
    logic [SB-1:0]      out_core_sel;
    logic [31:0]        pkt_in_cnt;
    logic [31:0]        pkt_out_cnt;

    int checks = 0;
    int errors = 0;
    logic [DW+CW-1:0] exp_q[$];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    pkt_core_dispatcher #(
        .DATA_WIDTH(DW), .CTRL_WIDTH(CW), .NUM_CORES(NC), .CORE_SEL_BITS(SB)
    ) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
        .core_in_data(core_in_data), .core_in_ctrl(core_in_ctrl),
        .core_in_wr(core_in_wr), .core_in_rdy(core_in_rdy),
        .core_out_req(core_out_req), .core_out_data(core_out_data),
        .core_out_ctrl(core_out_ctrl), .core_out_wr(core_out_wr),
        .core_out_rdy(core_out_rdy),
        .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
        .in_core_sel(in_core_sel), .out_core_sel(out_core_sel),
        .pkt_in_cnt(pkt_in_cnt), .pkt_out_cnt(pkt_out_cnt)
    );

    // Packet format: header word (ctrl FF), payload (ctrl 00), last word (ctrl 01).
    function automatic logic [CW-1:0] pkt_ctrl(input int j, input int len);
        if (j == 0) return 8'hFF;
        if (j == len - 1) return 8'h01;
        return 8'h00;
    endfunction

    // Egress word j of core i; core id sits in bits [35:32].
    function automatic logic [DW-1:0] core_word(input int i, input int j);
        return {16'hE600, 12'h000, 4'(i), 32'(j)};
    endfunction

    task automatic apply_reset;
        @(negedge clk);
        reset = 1'b1;
        in_wr = 1'b0;
        core_out_req = '0;
        core_out_wr = '0;
        out_rdy = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // ---------------- ingress driver ----------------
    // Holds each word with in_wr high until in_rdy is seen; optionally drops
    // the target core's ready for two cycles when word drop_at is pending.
    task automatic send_pkt(input int len, input int exp_core, input int exp_wait,
                            input logic [NC-1:0] rdy_mask, input int drop_at,
                            input logic [15:0] tag);
        int  idx;
        int  waits;
        int  cyc;
        int  drop_left;
        bit  started;
        bit  dropping;
        idx = 0; waits = 0; cyc = 0; drop_left = 2; started = 0;
        while (idx < len && cyc < 200) begin
            @(negedge clk);
            cyc++;
            in_wr   = 1'b1;
            in_data = {tag, 16'(exp_core), 32'(idx)};
            in_ctrl = pkt_ctrl(idx, len);
            dropping = (idx == drop_at) && (drop_left > 0);
            if (dropping) begin
                core_in_rdy = rdy_mask & ~(4'b0001 << exp_core);
                drop_left--;
            end else begin
                core_in_rdy = rdy_mask;
            end
            #1;
            if (dropping) begin
                checks++;
                if (in_rdy !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_rdy: in_rdy=%b required 0 while core %0d not ready", in_rdy, exp_core);
                end
            end
            if (in_rdy === 1'b1) begin
                started = 1;
                checks++;
                if (core_in_wr !== (4'b0001 << exp_core)) begin
                    errors++;
                    $display("FAIL in_strobe: core_in_wr=%b required core %0d, word %0d", core_in_wr, exp_core, idx);
                end
                checks++;
                if (in_core_sel !== SB'(exp_core)) begin
                    errors++;
                    $display("FAIL in_core_sel: got %0d required %0d", in_core_sel, exp_core);
                end
                checks++;
                if (core_in_data !== in_data || core_in_ctrl !== in_ctrl) begin
                    errors++;
                    $display("FAIL in_bcast: got %h/%h required %h/%h", core_in_data, core_in_ctrl, in_data, in_ctrl);
                end
                idx++;
            end else begin
                if (!started) waits++;
                checks++;
                if (core_in_wr !== '0) begin
                    errors++;
                    $display("FAIL in_idle_strobe: core_in_wr=%b required 0 while in_rdy low", core_in_wr);
                end
            end
        end
        checks++;
        if (idx < len) begin
            errors++;
            $display("FAIL in_timeout: %0d of %0d words accepted for core %0d", idx, len, exp_core);
        end
        if (exp_wait >= 0) begin
            checks++;
            if (waits != exp_wait) begin
                errors++;
                $display("FAIL in_gap: %0d in_rdy=0 cycles before packet, required %0d", waits, exp_wait);
            end
        end
    endtask

    // ---------------- egress driver + scoreboard ----------------
    // Each core in mask holds one packet; it raises core_out_req only before
    // its first word goes, so the request drops mid-packet.
    // With last_out at NC-1, requesters are served in ascending core order.
    task automatic run_egress(input logic [NC-1:0] mask, input int len, input bit toggle);
        int idx[NC];
        bit has[NC];
        bit acc[NC];
        bit prev_acc;
        bit busy;
        int cyc;
        logic [DW+CW-1:0] exp;
        exp_q.delete();
        prev_acc = 0; cyc = 0; busy = 1;
        for (int i = 0; i < NC; i++) begin
            idx[i] = 0;
            has[i] = mask[i];
            acc[i] = 0;
            if (mask[i]) begin
                for (int j = 0; j < len; j++) exp_q.push_back({pkt_ctrl(j, len), core_word(i, j)});
            end
        end
        while (cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (out_wr === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL out_extra: unexpected word %h/%h", out_ctrl, out_data);
                end else begin
                    exp = exp_q.pop_front();
                    if ({out_ctrl, out_data} !== exp) begin
                        errors++;
                        $display("FAIL out_word: got %h required %h", {out_ctrl, out_data}, exp);
                    end
                    checks++;
                    if (out_core_sel !== exp[32 +: SB]) begin
                        errors++;
                        $display("FAIL out_core_sel: got %0d required %0d", out_core_sel, exp[32 +: SB]);
                    end
                end
                checks++;
                if (!prev_acc) begin
                    errors++;
                    $display("FAIL out_latency: out_wr=1 with no word taken the cycle before");
                end
            end else begin
                checks++;
                if (prev_acc) begin
                    errors++;
                    $display("FAIL out_lost: word taken from core but out_wr=%b next cycle", out_wr);
                end
            end
            for (int i = 0; i < NC; i++) begin
                if (acc[i]) begin
                    idx[i]++;
                    if (idx[i] == len) has[i] = 0;
                end
            end
            busy = (exp_q.size() != 0);
            for (int i = 0; i < NC; i++) busy = busy | has[i];
            if (!busy) break;
            out_rdy = toggle ? ((cyc % 6) < 3) : 1'b1;
            for (int i = 0; i < NC; i++) begin
                core_out_req[i] = has[i] && (idx[i] == 0);
                core_out_wr[i]  = has[i];
                core_out_data[i*DW +: DW] = core_word(i, idx[i]);
                core_out_ctrl[i*CW +: CW] = pkt_ctrl(idx[i], len);
            end
            #2;
            checks++;
            if ($countones(core_out_rdy) > 1 || (!out_rdy && core_out_rdy !== '0)) begin
                errors++;
                $display("FAIL out_grant: core_out_rdy=%b with out_rdy=%b", core_out_rdy, out_rdy);
            end
            prev_acc = 0;
            for (int i = 0; i < NC; i++) begin
                acc[i] = core_out_wr[i] & core_out_rdy[i];
                prev_acc = prev_acc | acc[i];
            end
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL out_timeout: %0d words still expected", exp_q.size());
        end
        core_out_req = '0;
        core_out_wr = '0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (in_rdy !== 1'b0 || core_in_wr !== '0 || core_out_rdy !== '0) begin
            errors++;
            $display("FAIL reset_rdy: in_rdy=%b core_in_wr=%b core_out_rdy=%b required 0", in_rdy, core_in_wr, core_out_rdy);
        end
        checks++;
        if (out_wr !== 1'b0 || out_data !== '0 || out_ctrl !== '0) begin
            errors++;
            $display("FAIL reset_out: out_wr=%b out_data=%h out_ctrl=%h required 0", out_wr, out_data, out_ctrl);
        end
        checks++;
        if (in_core_sel !== '0 || out_core_sel !== '0 || pkt_in_cnt !== 32'd0 || pkt_out_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_regs: sel %0d/%0d cnt %0d/%0d required 0", in_core_sel, out_core_sel, pkt_in_cnt, pkt_out_cnt);
        end
        reset = 1'b0;
    endtask

    task automatic test_single_packet;
        send_pkt(8, 0, -1, 4'b1111, -1, 16'hA001);
        @(negedge clk);
        in_wr = 1'b0;
        #1;
        checks++;
        if (pkt_in_cnt !== 32'd1 || in_core_sel !== 2'd0) begin
            errors++;
            $display("FAIL single_pkt: pkt_in_cnt=%0d in_core_sel=%0d required 1/0", pkt_in_cnt, in_core_sel);
        end
        checks++;
        if (in_rdy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: in_rdy=%b required 0 right after EOP", in_rdy);
        end
    endtask

    task automatic test_back_to_back;
        core_in_rdy = 4'b1111;
        apply_reset();
        send_pkt(4, 0, -1, 4'b1111, -1, 16'hB000);
        send_pkt(4, 1, 1, 4'b1111, -1, 16'hB001);
        send_pkt(5, 2, 1, 4'b1111, -1, 16'hB002);
        send_pkt(3, 3, 1, 4'b1111, -1, 16'hB003);
        send_pkt(4, 0, 1, 4'b1111, -1, 16'hB004);
        @(negedge clk);
        in_wr = 1'b0;
        #1;
        checks++;
        if (pkt_in_cnt !== 32'd5) begin
            errors++;
            $display("FAIL b2b_count: pkt_in_cnt=%0d required 5", pkt_in_cnt);
        end
    endtask

    task automatic test_single_ready_stall;
        core_in_rdy = 4'b0100;
        apply_reset();
        send_pkt(6, 2, -1, 4'b0100, 3, 16'hC002);
        @(negedge clk);
        in_wr = 1'b0;
        #1;
        checks++;
        if (pkt_in_cnt !== 32'd1 || in_core_sel !== 2'd2) begin
            errors++;
            $display("FAIL stall_pkt: pkt_in_cnt=%0d in_core_sel=%0d required 1/2", pkt_in_cnt, in_core_sel);
        end
    endtask

    task automatic test_egress_order;
        core_in_rdy = 4'b0000;
        apply_reset();
        run_egress(4'b1010, 6, 1'b0);
        #1;
        checks++;
        if (pkt_out_cnt !== 32'd2 || out_core_sel !== 2'd3) begin
            errors++;
            $display("FAIL egress_cnt: pkt_out_cnt=%0d out_core_sel=%0d required 2/3", pkt_out_cnt, out_core_sel);
        end
    endtask

    task automatic test_out_rdy_toggle;
        apply_reset();
        run_egress(4'b0101, 5, 1'b1);
        #1;
        checks++;
        if (pkt_out_cnt !== 32'd2) begin
            errors++;
            $display("FAIL toggle_cnt: pkt_out_cnt=%0d required 2", pkt_out_cnt);
        end
    endtask

    task automatic test_reset_mid;
        // Previous test left last_out = 2, so core 2 is the only requester.
        @(negedge clk);
        core_in_rdy = 4'b1111;
        in_wr = 1'b1;
        in_data = 64'h0000_DEAD_0000_0000;
        in_ctrl = 8'hFF;
        core_out_req = 4'b0100;
        core_out_wr = 4'b0100;
        core_out_data[2*DW +: DW] = 64'h1234_5678_9ABC_DEF0;
        core_out_ctrl[2*CW +: CW] = 8'hFF;
        out_rdy = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (in_rdy !== 1'b1 || out_wr !== 1'b1) begin
            errors++;
            $display("FAIL mid_active: in_rdy=%b out_wr=%b required 1/1 before reset", in_rdy, out_wr);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (in_rdy !== 1'b0 || core_in_wr !== '0 || core_out_rdy !== '0 || out_wr !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_hs: in_rdy=%b core_in_wr=%b core_out_rdy=%b out_wr=%b required 0",
                     in_rdy, core_in_wr, core_out_rdy, out_wr);
        end
        checks++;
        if (out_data !== '0 || out_ctrl !== '0 || in_core_sel !== '0 || out_core_sel !== '0) begin
            errors++;
            $display("FAIL mid_reset_regs: out_data=%h out_ctrl=%h sel %0d/%0d required 0",
                     out_data, out_ctrl, in_core_sel, out_core_sel);
        end
        checks++;
        if (pkt_in_cnt !== 32'd0 || pkt_out_cnt !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset_cnt: pkt_in_cnt=%0d pkt_out_cnt=%0d required 0", pkt_in_cnt, pkt_out_cnt);
        end
        in_wr = 1'b0;
        core_out_req = '0;
        core_out_wr = '0;
        @(negedge clk);
        reset = 1'b0;
        send_pkt(4, 0, -1, 4'b1111, -1, 16'hD000);
        @(negedge clk);
        in_wr = 1'b0;
        #1;
        checks++;
        if (pkt_in_cnt !== 32'd1) begin
            errors++;
            $display("FAIL post_reset_in: pkt_in_cnt=%0d required 1", pkt_in_cnt);
        end
        run_egress(4'b1001, 3, 1'b0);
        #1;
        checks++;
        if (pkt_out_cnt !== 32'd2) begin
            errors++;
            $display("FAIL post_reset_out: pkt_out_cnt=%0d required 2", pkt_out_cnt);
        end
    endtask

    initial begin
        reset = 1'b1;
        in_data = '0;
        in_ctrl = '0;
        in_wr = 1'b0;
        core_in_rdy = '0;
        core_out_req = '0;
        core_out_data = '0;
        core_out_ctrl = '0;
        core_out_wr = '0;
        out_rdy = 1'b0;
        test_reset();
        test_single_packet();
        test_back_to_back();
        test_single_ready_stall();
        test_egress_order();
        test_out_rdy_toggle();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
